// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word RAM with RISC-V byte/half/word load-store, error flagging and wait states.
// Optional DMEM_CLEAR_EN: zero the whole RAM one word per cycle after reset.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [3:0]            cnt, cnt_nxt;
    logic [31:0]           mem [DEPTH];
    logic                  l_write;
    logic [2:0]            l_funct3;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [31:0]           l_wdata;
    logic                  accept, commit, st_we, legal, mis, oor, err;
    logic                  c_write;
    logic [2:0]            c_funct3;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_wdata, word, ld_data, st_data;
    logic [IW-1:0]         idx;
    logic [3:0]            be;
    logic [7:0]            lb;
    logic [15:0]           lh;
`ifdef DMEM_CLEAR_EN
    logic [IW-1:0]         clr_idx;
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    assign req_ready = !reset && (state == IDLE || state == RESP);
    assign accept    = req_valid && req_ready;

    // With no wait states the commit edge is the accept edge, so use the live request.
    assign c_write  = (WAIT_STATES == 0) ? req_write  : l_write;
    assign c_funct3 = (WAIT_STATES == 0) ? req_funct3 : l_funct3;
    assign c_addr   = (WAIT_STATES == 0) ? req_addr   : l_addr;
    assign c_wdata  = (WAIT_STATES == 0) ? req_wdata  : l_wdata;

    assign idx   = c_addr[IW+1:2];
    assign word  = mem[idx];
    assign legal = c_write ? (c_funct3 inside {3'b000, 3'b001, 3'b010})
                           : (c_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign mis   = (c_funct3[1:0] == 2'b01 && c_addr[0]) || (c_funct3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
    assign oor   = (c_addr >> (IW + 2)) != '0;
    assign err   = !legal || mis || oor;

    assign lb      = word[{c_addr[1:0], 3'b000} +: 8];
    assign lh      = c_addr[1] ? word[31:16] : word[15:0];
    assign ld_data = c_funct3[1] ? word :
                     c_funct3[0] ? {{16{~c_funct3[2] & lh[15]}}, lh} :
                                   {{24{~c_funct3[2] & lb[7]}}, lb};
    assign be      = c_funct3[1] ? 4'hF : c_funct3[0] ? (c_addr[1] ? 4'hC : 4'h3) : 4'b0001 << c_addr[1:0];
    assign st_data = c_funct3[1] ? c_wdata : c_funct3[0] ? {2{c_wdata[15:0]}} : {4{c_wdata[7:0]}};
    assign st_we   = commit && c_write && !err && !reset;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
`ifdef DMEM_CLEAR_EN
            CLEAR: state_nxt = (clr_idx == IW'(DEPTH - 1)) ? IDLE : CLEAR;
`else
            CLEAR: state_nxt = IDLE;
`endif
            WAIT: begin
                cnt_nxt   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                state_nxt = (cnt == 4'd0) ? RESP : WAIT;
                commit    = (cnt == 4'd0);
            end
            default: begin
                state_nxt = !accept ? IDLE : (WAIT_STATES == 0) ? RESP : WAIT;
                cnt_nxt   = (accept && WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : cnt;
                commit    = accept && (WAIT_STATES == 0);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_STATE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            l_write   <= 1'b0;
            l_funct3  <= 3'd0;
            l_addr    <= '0;
            l_wdata   <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= commit;
            rsp_error <= commit && err;
            rsp_rdata <= (commit && !err && !c_write) ? ld_data : 32'd0;
            if (accept) begin
                l_write  <= req_write;
                l_funct3 <= req_funct3;
                l_addr   <= req_addr;
                l_wdata  <= req_wdata;
            end
        end
    end

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clr_idx <= '0;
        else if (state == CLEAR)
            clr_idx <= clr_idx + 1'b1;
    end
`endif

    // RAM has no reset so contents survive reset unless the clear sweep runs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (st_we && be[i])
                mem[idx][8*i +: 8] <= st_data[8*i +: 8];
`ifdef DMEM_CLEAR_EN
        if (state == CLEAR && !reset)
            mem[clr_idx] <= 32'd0;
`endif
    end
endmodule
